// File: rtl/cacheline_adapter_pkg.sv
// Shared widths, line/beat types and FSM states for the cacheline-to-burst adapter.
package cacheline_adapter_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEATS  = LINE_W / DATA_W;
  localparam int unsigned CNT_W  = $clog2(BEATS);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);

  // A cacheline viewed as an array of bmem beats, beat 0 in the low bits.
  typedef logic [BEATS-1:0][DATA_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_CMD,
    READ_WAIT,
    RESP,
    COOL
  } cacheline_adapter_state_t;

  // Clears the byte-offset bits so the address points at the start of its line.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] a;
    a            = addr;
    a[OFF_W-1:0] = '0;
    return a;
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit dfp line request into a 4-beat 64-bit bmem burst and
// reassembles read beats into a line; every transaction ends with a dfp_resp pulse.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [DATA_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [DATA_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  cacheline_adapter_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_d;
  line_t             wdata_q, wdata_d;
  line_t             rdata_q, rdata_d;
  logic [DATA_W-1:0] wbeat_d;
  logic              last_beat;
  logic              beat_hit;

  // bmem_addr doubles as the latched line address; dfp_rdata as the read line.
  assign rdata_q   = line_t'(dfp_rdata);
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign beat_hit  = bmem_rvalid && (bmem_raddr == bmem_addr);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = bmem_addr;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        // Write has priority so a dirty eviction goes out before its refill.
        if (dfp_write) begin
          addr_d  = line_align(dfp_addr);
          wdata_d = line_t'(dfp_wdata);
          cnt_d   = '0;
          state_d = WRITE;
        end else if (dfp_read) begin
          addr_d  = line_align(dfp_addr);
          cnt_d   = '0;
          state_d = READ_CMD;
        end
      end
      WRITE: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      READ_CMD: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        // Beats tagged for another line are stale and silently dropped.
        if (beat_hit) begin
          rdata_d[cnt_q] = bmem_rdata;
          cnt_d          = cnt_q + CNT_W'(1);
          if (last_beat) state_d = RESP;
        end
      end
      // COOL swallows the request level the cache still holds after resp.
      RESP:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wbeat_d = (state_d == WRITE) ? wdata_d[cnt_d] : '0;

  // State, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      dfp_rdata  <= LINE_W'(rdata_d);
      dfp_resp   <= (state_d == RESP);
      bmem_addr  <= addr_d;
      bmem_read  <= (state_d == READ_CMD);
      bmem_write <= (state_d == WRITE);
      bmem_wdata <= wbeat_d;
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter: bursts, gaps, backpressure,
// eviction ordering, stale beats and mid-burst reset.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;

  cacheline_adapter dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] tag, input logic [63:0] data);
    bmem_rvalid = 1'b1;
    bmem_raddr  = tag;
    bmem_rdata  = data;
    tick();
    bmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b want 0", dfp_resp); end
    checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", bmem_read); end
    checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", bmem_write); end
    checks++; if (bmem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bmem_addr); end
    checks++; if (bmem_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bmem_wdata); end
    checks++; if (dfp_rdata !== 256'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dfp_rdata); end
  endtask

  task automatic test_write_burst();
    logic [63:0] exp_beat [4];
    exp_beat = '{64'hA, 64'hB, 64'hC, 64'hD};
    dfp_addr = 32'h0000_1234; dfp_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
    dfp_write = 1'b1; bmem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bmem_write !== 1'b1) begin errors++; $display("FAIL wr_strobe beat%0d: got %b want 1", i, bmem_write); end
      checks++; if (bmem_addr !== 32'h0000_1220) begin errors++; $display("FAIL wr_addr beat%0d: got %h want 00001220", i, bmem_addr); end
      checks++; if (bmem_wdata !== exp_beat[i]) begin errors++; $display("FAIL wr_data beat%0d: got %h want %h", i, bmem_wdata, exp_beat[i]); end
      checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL wr_early_resp beat%0d: got %b want 0", i, dfp_resp); end
    end
    tick();
    checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL wr_resp: got %b want 1", dfp_resp); end
    checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL wr_strobe_after: got %b want 0", bmem_write); end
    tick();
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL wr_resp_pulse: got %b want 0", dfp_resp); end
    checks++; if (bmem_write !== 1'b0) begin errors++; $display("FAIL wr_cool_write: got %b want 0", bmem_write); end
    dfp_write = 1'b0;
    tick();
    checks++; if ((bmem_write | bmem_read | dfp_resp) !== 1'b0) begin errors++; $display("FAIL wr_idle: got w=%b r=%b resp=%b want 0", bmem_write, bmem_read, dfp_resp); end
  endtask

  task automatic test_read_gaps();
    dfp_addr = 32'h0000_8040; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    checks++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL rd_cmd: got %b want 1", bmem_read); end
    checks++; if (bmem_addr !== 32'h0000_8040) begin errors++; $display("FAIL rd_addr: got %h want 00008040", bmem_addr); end
    tick();
    checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL rd_cmd_once: got %b want 0", bmem_read); end
    for (int i = 0; i < 4; i++) begin
      tick(); tick();
      checks++; if ((dfp_resp | bmem_read) !== 1'b0) begin errors++; $display("FAIL rd_gap%0d: got resp=%b read=%b want 0", i, dfp_resp, bmem_read); end
      send_beat(32'h0000_8040, 64'(i + 1));
      if (i < 3) begin
        checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_early_resp beat%0d: got %b want 0", i, dfp_resp); end
      end
    end
    checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL rd_resp: got %b want 1", dfp_resp); end
    checks++; if (dfp_rdata !== {64'd4, 64'd3, 64'd2, 64'd1}) begin errors++; $display("FAIL rd_line: got %h want 4/3/2/1", dfp_rdata); end
    tick();
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rd_resp_pulse: got %b want 0", dfp_resp); end
    dfp_read = 1'b0;
    tick();
    checks++; if (dfp_rdata !== {64'd4, 64'd3, 64'd2, 64'd1}) begin errors++; $display("FAIL rd_line_hold: got %h", dfp_rdata); end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_beat [4];
    exp_beat = '{64'h11, 64'h22, 64'h33, 64'h44};
    dfp_addr = 32'h0000_2000; dfp_wdata = {64'h44, 64'h33, 64'h22, 64'h11};
    dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    checks++; if (bmem_wdata !== exp_beat[0]) begin errors++; $display("FAIL bp_beat0: got %h want 11", bmem_wdata); end
    tick();
    checks++; if (bmem_wdata !== exp_beat[1]) begin errors++; $display("FAIL bp_beat1: got %h want 22", bmem_wdata); end
    bmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bmem_write !== 1'b1 || bmem_wdata !== exp_beat[1]) begin errors++; $display("FAIL bp_hold%0d: got w=%b d=%h want 1/22", i, bmem_write, bmem_wdata); end
    end
    bmem_ready = 1'b1;
    tick();
    checks++; if (bmem_wdata !== exp_beat[2]) begin errors++; $display("FAIL bp_beat2: got %h want 33", bmem_wdata); end
    tick();
    checks++; if (bmem_wdata !== exp_beat[3] || dfp_resp !== 1'b0) begin errors++; $display("FAIL bp_beat3: got d=%h resp=%b want 44/0", bmem_wdata, dfp_resp); end
    tick();
    checks++; if (dfp_resp !== 1'b1 || bmem_write !== 1'b0) begin errors++; $display("FAIL bp_resp: got resp=%b w=%b want 1/0", dfp_resp, bmem_write); end
    tick();
    dfp_write = 1'b0;
    tick();
    // Read command held while memory is not ready.
    dfp_addr = 32'h0000_3000; dfp_read = 1'b1; bmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bmem_read !== 1'b1) begin errors++; $display("FAIL bp_cmd_hold%0d: got %b want 1", i, bmem_read); end
    end
    bmem_ready = 1'b1;
    tick();
    checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL bp_cmd_drop: got %b want 0", bmem_read); end
    for (int i = 0; i < 4; i++) send_beat(32'h0000_3000, 64'h100 + 64'(i));
    checks++; if (dfp_resp !== 1'b1 || dfp_rdata !== {64'h103, 64'h102, 64'h101, 64'h100}) begin errors++; $display("FAIL bp_rd_line: got resp=%b line=%h", dfp_resp, dfp_rdata); end
    tick();
    dfp_read = 1'b0;
    tick();
  endtask

  task automatic test_dirty_eviction();
    dfp_addr = 32'h0000_4000; dfp_wdata = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    dfp_write = 1'b1; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    checks++; if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_addr !== 32'h0000_4000) begin errors++; $display("FAIL ev_write_first: got w=%b r=%b a=%h", bmem_write, bmem_read, bmem_addr); end
    tick(); tick(); tick();
    checks++; if (bmem_wdata !== 64'hE3) begin errors++; $display("FAIL ev_last_beat: got %h want e3", bmem_wdata); end
    tick();
    checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL ev_wr_resp: got %b want 1", dfp_resp); end
    tick();
    dfp_write = 1'b0; dfp_addr = 32'h0000_5000;
    checks++; if ((bmem_read | bmem_write | dfp_resp) !== 1'b0) begin errors++; $display("FAIL ev_cool: got r=%b w=%b resp=%b want 0", bmem_read, bmem_write, dfp_resp); end
    tick();
    checks++; if (bmem_read !== 1'b0) begin errors++; $display("FAIL ev_cool_ignores_read: got %b want 0", bmem_read); end
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_5000) begin errors++; $display("FAIL ev_read_cmd: got r=%b a=%h want 1/00005000", bmem_read, bmem_addr); end
    tick();
    for (int i = 0; i < 4; i++) send_beat(32'h0000_5000, 64'h50 + 64'(i));
    checks++; if (dfp_resp !== 1'b1 || dfp_rdata !== {64'h53, 64'h52, 64'h51, 64'h50}) begin errors++; $display("FAIL ev_rd_resp: got resp=%b line=%h", dfp_resp, dfp_rdata); end
    tick();
    dfp_read = 1'b0;
    tick();
  endtask

  task automatic test_stale_raddr();
    dfp_addr = 32'h0000_6000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick(); tick();
    send_beat(32'h0000_6000, 64'hAA);
    send_beat(32'h0000_7000, 64'hBAD);
    send_beat(32'h0000_6000, 64'hBB);
    send_beat(32'h0000_6000, 64'hCC);
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL stale_counted: got resp=%b want 0", dfp_resp); end
    send_beat(32'h0000_6000, 64'hDD);
    checks++; if (dfp_resp !== 1'b1) begin errors++; $display("FAIL stale_resp: got %b want 1", dfp_resp); end
    checks++; if (dfp_rdata !== {64'hDD, 64'hCC, 64'hBB, 64'hAA}) begin errors++; $display("FAIL stale_line: got %h want dd/cc/bb/aa", dfp_rdata); end
    tick();
    dfp_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int resp_cnt = 0;
    dfp_addr = 32'h0000_9000; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick(); tick();
    send_beat(32'h0000_9000, 64'h91);
    send_beat(32'h0000_9000, 64'h92);
    rst = 1'b1; dfp_read = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if ((dfp_resp | bmem_read | bmem_write) !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got resp=%b r=%b w=%b want 0", dfp_resp, bmem_read, bmem_write); end
    checks++; if (bmem_addr !== 32'h0 || bmem_wdata !== 64'h0 || dfp_rdata !== 256'h0) begin errors++; $display("FAIL mid_rst_data: got a=%h d=%h line=%h want 0", bmem_addr, bmem_wdata, dfp_rdata); end
    // Remaining beats of the abandoned burst must not produce a response.
    send_beat(32'h0000_9000, 64'h93);
    send_beat(32'h0000_9000, 64'h94);
    checks++; if (dfp_resp !== 1'b0) begin errors++; $display("FAIL mid_rst_spurious: got %b want 0", dfp_resp); end
    dfp_addr = 32'h0000_A000; dfp_read = 1'b1;
    tick();
    checks++; if (bmem_read !== 1'b1 || bmem_addr !== 32'h0000_A000) begin errors++; $display("FAIL mid_rst_new_cmd: got r=%b a=%h", bmem_read, bmem_addr); end
    tick();
    for (int i = 0; i < 4; i++) begin
      send_beat(32'h0000_A000, 64'hA0 + 64'(i));
      if (dfp_resp) resp_cnt++;
    end
    checks++; if (dfp_rdata !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin errors++; $display("FAIL mid_rst_new_line: got %h", dfp_rdata); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dfp_resp) resp_cnt++;
      if (i == 0) dfp_read = 1'b0;
    end
    checks++; if (resp_cnt !== 1) begin errors++; $display("FAIL mid_rst_resp_count: got %0d want 1", resp_cnt); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_gaps();
    test_backpressure();
    test_dirty_eviction();
    test_stale_raddr();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
Name: cacheline_adapter

Overview:
Responder side of the cache's dfp (downstream-facing port) interface. Accepts one 256-bit cacheline read or write request from the pipelined cache and converts it into a 4-beat, 64-bit burst transaction on the bmem interface. For reads, it reassembles the returned beats into a full line. It completes every transaction with a single-cycle dfp_resp pulse. Sits between the cache's second stage and the burst memory model/arbiter.

Parameters:
DATA_W, 64, bmem beat width in bits
LINE_W, 256, cacheline width in bits
BEATS, LINE_W/DATA_W (=4), beats per burst; must be a power of two ≥2

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
dfp_addr  input  32  line request address; bits [4:0] ignored
dfp_read  input  1  line read request, level, held until dfp_resp
dfp_write  input  1  line write request, level, held until dfp_resp
dfp_wdata  input  LINE_W  write line, valid with dfp_write
dfp_rdata  output  LINE_W  assembled read line
dfp_resp  output  1  one-cycle completion pulse
bmem_addr  output  32  burst address, line aligned
bmem_read  output  1  read burst command, one cycle
bmem_write  output  1  write beat strobe
bmem_wdata  output  DATA_W  write beat data
bmem_ready  input  1  memory can accept command/beat this cycle
bmem_raddr  input  32  address tag of returning read beat
bmem_rdata  input  DATA_W  read beat data
bmem_rvalid  input  1  read beat valid

Behaviour:
- Reset: rst is synchronous, active-high, one clock (clk). In reset, state=IDLE and beat counter=0. dfp_resp, bmem_read, bmem_write=0. bmem_addr, bmem_wdata, dfp_rdata=0. Latched addr/wdata=0. Reset mid-burst abandons the burst with no dfp_resp.
- States: IDLE, WRITE, READ_CMD, READ_WAIT, RESP, COOL.
- IDLE: on dfp_write=1, latch {dfp_addr[31:5],5'b0} and dfp_wdata, then go to WRITE. Else on dfp_read=1, latch the address and go to READ_CMD. If both are high, the write wins; the read is served as a separate later request. Acceptance is not gated by bmem_ready.
- WRITE: bmem_write=1 and bmem_addr=latched addr, held for the whole burst. bmem_wdata=wdata_latch[k*DATA_W +: DATA_W], where k is the beat counter. The beat advances only in cycles with bmem_ready=1. If bmem_ready=0, the same beat is held with bmem_write still 1. After beat BEATS-1 is accepted, go to RESP.
- READ_CMD: bmem_read=1 and bmem_addr=latched addr. When bmem_ready=1, the command is accepted; go to READ_WAIT with counter=0. Otherwise hold the command.
- READ_WAIT: on bmem_rvalid=1 with bmem_raddr==latched addr, write bmem_rdata into line slice k and increment k. rvalid beats with a mismatched raddr are dropped. Gaps between beats are allowed. When the last beat is captured, go to RESP.
- RESP: dfp_resp=1 for exactly one cycle. dfp_rdata holds the assembled line (for a write, it holds the prior contents). dfp_rdata stays stable until the next read's first beat. Go to COOL.
- COOL: one cycle in which all dfp requests are ignored. The cache drops its request from a registered copy of resp, so the stale level must not be re-accepted. Go to IDLE.
- Latency, read: accept cycle, then cmd ≥1 cycle, then beats, then RESP. With zero-wait memory and beats arriving on the cycle after the command, dfp_resp comes BEATS+2 cycles after the IDLE accept.
- Latency, write: RESP is BEATS+1 cycles after the IDLE accept when bmem_ready stays high.
- Beat counter width is clog2(BEATS) and wraps to 0 on the last beat.
- Only one outstanding transaction; no new bmem command is issued before dfp_resp.
- dfp_addr/dfp_wdata changes after acceptance have no effect.

Decomposition:
- Shared package (rv32i_types or a new cache_pkg): cacheline_adapter_state_t enum {IDLE, WRITE, READ_CMD, READ_WAIT, RESP, COOL}; constants LINE_W, DATA_W, BEATS.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Write burst: dfp_write, addr 0x0000_1234, wdata={64'hD,64'hC,64'hB,64'hA}, bmem_ready=1. Expect bmem_write high 4 cycles, bmem_addr=0x0000_1220, beats A,B,C,D in order, then dfp_resp 1 cycle, then COOL.
- Read with gaps: dfp_read addr 0x0000_8040. Expect one bmem_read cycle. Return beats 1,2,3,4 with 2-cycle gaps and raddr=0x8040. Expect dfp_rdata={4,3,2,1} and exactly one dfp_resp after the 4th beat.
- Backpressure: bmem_ready=0 on write beat 2 for 3 cycles. Expect beat 2 data held and bmem_write=1 throughout, no skipped or duplicated beat, resp after beat 4. bmem_ready=0 in READ_CMD holds bmem_read.
- Dirty eviction: dfp_write and dfp_read both high at different addresses. Expect the write burst, then dfp_resp, then COOL ignoring the still-high read, then the read burst and a second dfp_resp.
- Stale raddr: a beat with raddr≠latched addr during READ_WAIT is not captured and does not advance the counter.
- Reset mid-read after 2 beats: all outputs 0 next cycle and state IDLE. A new read completes correctly with no spurious dfp_resp.
